// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end.
package fetch_pkg;
  typedef logic [31:0] pc_t;
  typedef logic [31:0] instr_t;
  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } fetch_entry_t;
  localparam instr_t INSTR_NOP = 32'h0;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of fetched {pc, instr} entries with flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  fetch_entry_t                 din,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_entry_t                 head
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= din;
  assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, single in-flight imem read, prefetch queue and redirect squash.
// Define FETCH_BYPASS_EN to forward a returning word straight to decode when the queue is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd1,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  pc_t           pc_q, infl_pc_q;
  logic          infl_v_q, issue, out_fire, byp, push, pop;
  logic [CW-1:0] count_q;
  fetch_entry_t  head;
  assign imem_pc = redirect_valid ? redirect_pc : pc_q;
`ifdef FETCH_BYPASS_EN
  assign byp = (count_q == '0) && infl_v_q;
`else
  assign byp = 1'b0;
`endif
  assign out_valid = !redirect_valid && ((count_q != '0) || byp);
  assign out_pc    = !out_valid ? '0 : byp ? infl_pc_q : head.pc;
  assign out_instr = !out_valid ? INSTR_NOP : byp ? imem_instr : head.instr;
  assign out_fire  = out_valid && out_ready;
  // A bypassed word that decode takes this cycle never occupies the queue.
  assign push  = infl_v_q && !(byp && out_fire);
  assign pop   = out_fire && !byp;
  assign issue = redirect_valid ||
                 (int'(count_q) + int'(infl_v_q) - int'(out_fire) < DEPTH);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      infl_v_q  <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      infl_v_q <= issue;
      if (issue) begin
        infl_pc_q <= imem_pc;
        pc_q      <= imem_pc + PC_STEP;
      end
    end
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   ('{pc: infl_pc_q, instr: imem_instr}),
    .count (count_q),
    .head  (head)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench; the model is the expected PC stream plus fetch latency.
module tb_fetch_unit;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam int DEPTH = 2;
  logic        clk, rst_n;
  logic [31:0] imem_pc, imem_instr, redirect_pc, out_instr, out_pc;
  logic        redirect_valid, out_valid, out_ready;
  int n_cmp = 0;
  int n_bad = 0;
  fetch_unit #(.RESET_PC(32'd0), .PC_STEP(32'd1), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) imem_instr <= 32'h1000 + imem_pc;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: next PC decode must see, and clean cycles since the last redirect/reset release.
  logic [31:0] exp_pc = 32'd0;
  int          clean = -1;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", out_valid, 0);
      chk("rst_pc", out_pc, 0);
      chk("rst_instr", out_instr, 0);
      exp_pc = 32'd0;
      clean  = -1;
    end else if (redirect_valid) begin
      chk("redir_valid", out_valid, 0);
      exp_pc = redirect_pc;
      clean  = 0;
    end else begin
      if (clean < 1000) clean++;
      chk("valid", out_valid, 32'(clean >= LAT));
      if (out_valid) begin
        chk("pc", out_pc, exp_pc);
        chk("instr", out_instr, 32'h1000 + exp_pc);
        if (out_ready) exp_pc = exp_pc + 32'd1;
      end
    end
  end
  initial begin
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (LAT) @(negedge clk);
    chk("lit_first_not_yet", out_valid, 0);
    @(negedge clk);
    chk("lit_first_valid", out_valid, 1);
    chk("lit_first_pc", out_pc, 0);
    chk("lit_first_instr", out_instr, 32'h1000);
    @(negedge clk);
    chk("lit_second_pc", out_pc, 1);
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("lit_stall_count", 32'(dut.count_q), DEPTH);
    chk("lit_stall_head", out_pc, 2);
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 redirect_valid = 1'b1; redirect_pc = 32'd20;
    @(negedge clk);
    chk("lit_redir_valid", out_valid, 0);
    @(posedge clk); #1 redirect_valid = 1'b0;
    repeat (LAT) @(negedge clk);
    chk("lit_redir_target", out_pc, 20);
    chk("lit_redir_tvalid", out_valid, 1);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("lit_async_rst_valid", out_valid, 0);
    chk("lit_async_rst_pc", out_pc, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    chk("lit_restart_pc", out_pc, 0);
    chk("lit_restart_valid", out_valid, 1);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      out_ready      = $urandom_range(0, 3) != 0;
      redirect_valid = $urandom_range(0, 11) == 0;
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 200));
      rst_n          = (i % 997) != 500;
    end
    @(posedge clk); #1 redirect_valid = 1'b0; rst_n = 1'b1;
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end of the MIPS processor, sitting directly upstream of the instruction memory. It owns the program counter, presents a word index to the instruction memory every cycle, tracks the single in-flight read (one-cycle synchronous read latency), and buffers the returned instructions with their PCs. It hands them to decode over a valid/ready handshake and handles branch/jump redirects by squashing wrong-path work.

## Interface
Parameters:
- RESET_PC, 32'd0, PC loaded on reset (word index).
- PC_STEP, 32'd1, PC increment per sequential fetch (instruction memory is word-indexed).
- DEPTH, 2, prefetch queue entries; legal range 2..8.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_pc  output  32  address presented to instruction memory; sampled by it on the rising edge.
- imem_instr  input  32  instruction memory output: the word at the imem_pc of the previous cycle.
- redirect_valid  input  1  branch/jump taken; squash and refetch.
- redirect_pc  input  32  redirect target.
- out_valid  output  1  out_instr/out_pc hold a valid instruction.
- out_ready  input  1  decode accepts this cycle.
- out_instr  output  32  instruction to decode.
- out_pc  output  32  PC of out_instr.

## Operation
- State: pc_q (next sequential PC), infl_v_q/infl_pc_q (in-flight read), circular queue of DEPTH {pc, instr} entries with rd_ptr, wr_ptr, count_q (width clog2(DEPTH+1)).
- imem_pc = redirect_valid ? redirect_pc : pc_q (combinational).
- out_fire = out_valid & out_ready & ~redirect_valid.
- issue = redirect_valid | (count_q + infl_v_q - out_fire < DEPTH).
- On issue: infl_v_q<=1, infl_pc_q<=imem_pc, pc_q<=imem_pc+PC_STEP (32-bit wrap, 0xFFFFFFFF+1=0). Otherwise infl_v_q<=0, pc_q holds; the memory read still occurs but is ignored.
- Return: when infl_v_q=1, {infl_pc_q, imem_instr} is written to the queue tail (unless bypassed, see Configuration).
- Dequeue on out_fire; out_instr/out_pc come from the queue head; out_valid = count_q != 0.
- Redirect (highest priority): queue cleared (count_q<=0, pointers reset), returning in-flight word discarded, out_valid forced 0 that cycle, target issued that same cycle.
- Simultaneous enqueue and dequeue: count_q unchanged.
- Queue never overflows by construction of the issue condition.

## Timing
- Reset values: pc_q=RESET_PC, infl_v_q=0, count_q=0, pointers 0, out_valid=0, out_instr=0, out_pc=0.
- Reset assertion mid-operation clears everything immediately. First issue of RESET_PC happens in the first cycle after release.
- Latency from issue to out_valid: 2 cycles (1 cycle with bypass).
- Throughput: 1 instruction/cycle while out_ready=1.
- Redirect penalty: target instruction reaches out_valid 2 cycles after the redirect cycle (1 with bypass).
- out_ready low: queue fills to DEPTH and issue stops. Outputs are held stable while out_valid & ~out_ready, except on redirect.

## Configuration
- FETCH_BYPASS_EN defined: when count_q=0 and infl_v_q=1, the returning word drives out_instr/out_pc directly, with out_valid=1 in the same cycle. If out_fire, it is not enqueued; otherwise it is enqueued.
- FETCH_BYPASS_EN undefined: every returned word passes through the queue, giving one extra cycle of latency and no combinational path from imem_instr to outputs.

## Structure
- fetch_pkg holds: pc_t and instr_t typedefs (32-bit), fetch_entry_t struct {pc_t pc; instr_t instr;}, and constant INSTR_NOP=32'h0.
- Sub-module fetch_queue: parameterised circular FIFO of fetch_entry_t with push, pop, flush, count, head. fetch_unit holds the PC/in-flight logic and the issue/redirect control.

## Test plan
- Reset then out_ready=1, memory word k = 32'h1000+k, no bypass → out_valid first at cycle 2 after release with out_pc=0, out_instr=32'h1000, then pc 1,2,3… one per cycle.
- out_ready=0 for 6 cycles after the first valid → count_q saturates at DEPTH=2; on release, pcs 0,1,2 are delivered in order with no gaps or duplicates.
- redirect_valid with redirect_pc=20 while pcs 5..6 are queued → out_valid=0 that cycle; next delivered out_pc=20 two cycles later; pcs 5..7 never appear.
- Redirect in the same cycle as out_valid&out_ready → that instruction is not consumed (out_fire=0); the stream resumes at the target.
- rst_n pulsed low mid-stream at pc 9 → outputs go to 0 immediately; the stream restarts at RESET_PC.
- FETCH_BYPASS_EN defined, out_ready=1 → out_pc=0 valid 1 cycle after release; redirect penalty is 1 cycle.
